uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler that shares a single `uart_tx` transmitter between `N` byte requesters. It sits directly in front of the transmitter's parallel interface and drives `tx_i_data` and `tx_i_data_valid`. It paces bytes using the transmitter's `tx_o_ready`. A grant is held for a whole packet (until `req_last`), capped at `MAX_BURST` bytes, so no single requester can starve the others.

## Interface
- `N`, default 4: number of requesters, 2..16.
- `MAX_BURST`, default 16: maximum bytes sent per grant before forced re-arbitration, 1..255.
- `BUSY_TIMEOUT`, default 64: cycles allowed in BUSY for `tx_o_ready` to fall, 2..255.
- `tx_clk`, in, 1: single clock, rising edge.
- `tx_en`, in, 1: reset, synchronous and active-low. Scheduler is held in reset while low.
- `req_valid`, in, N: requester i has a byte on `req_data[8i+7:8i]`.
- `req_data`, in, 8*N: flattened byte lanes.
- `req_last`, in, N: byte offered by requester i is the last byte of its packet.
- `req_ready`, out, N: one-hot. The byte is consumed at the edge where `req_valid[i] && req_ready[i]`.
- `tx_i_data`, out, 8: byte to the transmitter. Registered.
- `tx_i_data_valid`, out, 1: byte offered to the transmitter. Registered.
- `tx_o_ready`, in, 1: transmitter idle and able to accept.
- `grant_id`, out, clog2(N): current or last granted requester.
- `busy`, out, 1: high in OFFER and BUSY.
- `tx_err`, out, 1: one-cycle pulse when a BUSY timeout occurs.

## Operation
- **Reset** (`tx_en`=0 at an edge): state goes to IDLE. Outputs reset as follows:
  - `tx_i_data`=0, `tx_i_data_valid`=0, `grant_id`=0, `busy`=0, `tx_err`=0.
  - `req_ready`=0 (combinational, forced 0 while `tx_en`=0).
  - Round-robin pointer `last`=N-1, so requester 0 wins first.
  - `burst_cnt`=0, `fell`=0, `tmo_cnt`=0.
- **Arbitration**: the winner is the first i with `req_valid[i]`=1, scanning `last+1, last+2, …` modulo N.
- **IDLE**
  - If any `req_valid` is high: `req_ready[winner]`=1 combinationally.
  - At that edge:
    - `grant_id`←winner, `last`←winner.
    - `tx_i_data`←byte, `tx_i_data_valid`←1.
    - `lastflag`←`req_last[winner]`, `burst_cnt`←1.
    - Go to OFFER.
- **OFFER**
  - `tx_i_data_valid` is held at 1.
  - At an edge with `tx_o_ready`=1, the byte is accepted: `tx_i_data_valid`←0, `fell`←0, `tmo_cnt`←0, go to BUSY.
- **BUSY**
  - Each cycle, `tmo_cnt` increments. `fell`←1 once `tx_o_ready`=0 is sampled.
  - The byte is complete when `fell`=1 and `tx_o_ready`=1.
  - On `tmo_cnt`=`BUSY_TIMEOUT`-1 with `fell`=0: pulse `tx_err` and treat the byte as complete.
- **On completion**, exactly one of the following applies:
  - **Continue**: `lastflag`=0, `burst_cnt`<`MAX_BURST`, and `req_valid[grant_id]`=1.
    - `req_ready[grant_id]`=1 in the completion cycle.
    - Load the byte, `burst_cnt`+1, go to OFFER.
  - **Release**: any other case. Go to IDLE; the next arbitration starts after `grant_id`.
  - A requester that deasserts mid-packet loses the grant. Its packet resumes at its next turn.
- `req_ready` is never high outside IDLE-with-request or a continue-completion cycle.
- `req_valid` changing while `req_ready`=0 has no effect.

## Timing
- Request to `tx_i_data_valid` high: 1 cycle (arbitration edge).
- `tx_o_ready` high in OFFER: `tx_i_data_valid` drops on the following cycle.
- Minimum per-byte overhead in the scheduler: 1 cycle after the transmitter reasserts `tx_o_ready`. The next byte is valid at the completion edge.
- Simultaneous `tx_o_ready` fall and timeout terminal count: the fall wins. No `tx_err`, keep waiting.
- `tx_en` low mid-OFFER or mid-BUSY: reset at that edge. The in-flight byte is dropped and no `req_ready` is issued.
- `MAX_BURST`=1: every byte forces re-arbitration.
- `burst_cnt` is 8 bits and never wraps, because `MAX_BURST` ≤255.

## Test plan
- **Single byte**: N=4, requester 2 sends 0xA5 with last=1. Expect `req_ready[2]` for 1 cycle, `tx_i_data`=0xA5 with valid on the next cycle, `grant_id`=2, and a return to IDLE after `tx_o_ready` 1→0→1.
- **Round robin**: requesters 0 and 1 each hold single-byte packets continuously. Expect grants to alternate 0,1,0,1 starting with 0 after reset.
- **Packet lock**: requester 3 sends 0x11, 0x22, 0x33 (last on 0x33) while requester 0 is also requesting. Expect three consecutive bytes from requester 3, then `grant_id`=0.
- **Burst cap**: `MAX_BURST`=2, requester 1 sends 5 bytes with no last, requester 2 is waiting. Expect the order 1,1,2,1,1,…
- **Timeout**: `tx_o_ready` is stuck at 1 after acceptance. Expect a `tx_err` pulse exactly `BUSY_TIMEOUT` cycles after entering BUSY, followed by release or continue.
- **Reset mid-transfer**: `tx_en`=0 for 1 cycle during OFFER. Expect all outputs 0, IDLE, requester 0 highest priority, and the dropped byte not re-sent.

Source files
------------

// File: rtl/uart_tx_sched.sv
`timescale 1ns/1ps
// Round-robin scheduler sharing one UART transmitter among N byte requesters; grant held per packet, capped at MAX_BURST bytes.
// Byte reaches tx_i_data one edge after req_ready; pacing follows tx_o_ready fall/rise, with a BUSY watchdog raising tx_err.
module uart_tx_sched #(
    parameter int N            = 4,
    parameter int MAX_BURST    = 16,
    parameter int BUSY_TIMEOUT = 64,
    localparam int GW          = (N > 1) ? $clog2(N) : 1
) (
    input  logic            tx_clk,
    input  logic            tx_en,
    input  logic [N-1:0]    req_valid,
    input  logic [8*N-1:0]  req_data,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    req_ready,
    output logic [7:0]      tx_i_data,
    output logic            tx_i_data_valid,
    input  logic            tx_o_ready,
    output logic [GW-1:0]   grant_id,
    output logic            busy,
    output logic            tx_err
);

    typedef enum logic [1:0] {S_IDLE, S_OFFER, S_BUSY} state_t;

    state_t          state;
    logic [GW-1:0]   last;
    logic            lastflag;
    logic [7:0]      burst_cnt;
    logic [7:0]      tmo_cnt;
    logic            fell;

    logic            any_req;
    logic [GW-1:0]   winner;
    logic            tmo_hit;
    logic            done;
    logic            cont;
    logic [7:0]      win_byte;
    logic [7:0]      gnt_byte;

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % N;
        return GW'(s);
    endfunction

    // Scan starts just after the previous winner, so the last granted requester has lowest priority.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        for (int k = 1; k <= N; k++) begin
            if (!any_req && req_valid[rr_idx(last, k)]) begin
                any_req = 1'b1;
                winner  = rr_idx(last, k);
            end
        end
    end

    assign win_byte = req_data[{winner, 3'b000} +: 8];
    assign gnt_byte = req_data[{grant_id, 3'b000} +: 8];

    // A ready fall sampled on the terminal count beats the timeout.
    assign tmo_hit = (state == S_BUSY) && !fell && tx_o_ready && (tmo_cnt == 8'(BUSY_TIMEOUT - 1));
    assign done    = (state == S_BUSY) && ((fell && tx_o_ready) || tmo_hit);
    assign cont    = !lastflag && (burst_cnt < 8'(MAX_BURST)) && req_valid[grant_id];

    always_comb begin
        req_ready = '0;
        if (tx_en) begin
            if (state == S_IDLE && any_req) begin
                req_ready[winner] = 1'b1;
            end else if (done && cont) begin
                req_ready[grant_id] = 1'b1;
            end
        end
    end

    always_ff @(posedge tx_clk) begin
        if (!tx_en) begin
            state           <= S_IDLE;
            last            <= GW'(N - 1);
            lastflag        <= 1'b0;
            burst_cnt       <= 8'd0;
            tmo_cnt         <= 8'd0;
            fell            <= 1'b0;
            tx_i_data       <= 8'd0;
            tx_i_data_valid <= 1'b0;
            grant_id        <= '0;
            busy            <= 1'b0;
            tx_err          <= 1'b0;
        end else begin
            tx_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant_id        <= winner;
                        last            <= winner;
                        tx_i_data       <= win_byte;
                        tx_i_data_valid <= 1'b1;
                        lastflag        <= req_last[winner];
                        burst_cnt       <= 8'd1;
                        busy            <= 1'b1;
                        state           <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (tx_o_ready) begin
                        tx_i_data_valid <= 1'b0;
                        fell            <= 1'b0;
                        tmo_cnt         <= 8'd0;
                        state           <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (tmo_cnt != 8'hFF) begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                    if (!tx_o_ready) begin
                        fell <= 1'b1;
                    end
                    tx_err <= tmo_hit;
                    if (done) begin
                        if (cont) begin
                            tx_i_data       <= gnt_byte;
                            tx_i_data_valid <= 1'b1;
                            lastflag        <= req_last[grant_id];
                            burst_cnt       <= burst_cnt + 8'd1;
                            state           <= S_OFFER;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_sched: two instances (MAX_BURST 16 and 2) fed by requester queues and a UART transmitter model.
module tb_uart_tx_sched;
    localparam int N  = 4;
    localparam int GW = 2;
    localparam int BT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            tx_en;
    logic [N-1:0]    req_valid [2];
    logic [8*N-1:0]  req_data  [2];
    logic [N-1:0]    req_last  [2];
    logic [N-1:0]    req_ready [2];
    logic [7:0]      tx_data   [2];
    logic            tx_vld    [2];
    logic            tx_rdy    [2];
    logic [GW-1:0]   gid       [2];
    logic            busy      [2];
    logic            err       [2];

    uart_tx_sched #(.N(N), .MAX_BURST(16), .BUSY_TIMEOUT(BT)) dut (
        .tx_clk(clk), .tx_en(tx_en), .req_valid(req_valid[0]), .req_data(req_data[0]),
        .req_last(req_last[0]), .req_ready(req_ready[0]), .tx_i_data(tx_data[0]),
        .tx_i_data_valid(tx_vld[0]), .tx_o_ready(tx_rdy[0]), .grant_id(gid[0]),
        .busy(busy[0]), .tx_err(err[0]));

    uart_tx_sched #(.N(N), .MAX_BURST(2), .BUSY_TIMEOUT(BT)) dut_b (
        .tx_clk(clk), .tx_en(tx_en), .req_valid(req_valid[1]), .req_data(req_data[1]),
        .req_last(req_last[1]), .req_ready(req_ready[1]), .tx_i_data(tx_data[1]),
        .tx_i_data_valid(tx_vld[1]), .tx_o_ready(tx_rdy[1]), .grant_id(gid[1]),
        .busy(busy[1]), .tx_err(err[1]));

    // Requester byte queues ({last,data}) and log of bytes the transmitter accepted ({grant_id,data}).
    logic [8:0]  mem    [2][N][16];
    int          wr_cnt [2][N];
    int          rd_cnt [2][N];
    logic [9:0]  log_q  [2][64];
    int          log_n  [2];
    int          left   [2];
    int          pre    [2];
    logic        stuck  [2];
    int          dly    [2];

    int vectors = 0;
    int fails   = 0;

    // Transmitter + requester model: sample at negedge, update 1 ns after posedge.
    initial begin
        logic        acc   [2];
        logic [9:0]  acc_b [2];
        logic [N-1:0] cons [2];
        for (int d = 0; d < 2; d++) begin
            tx_rdy[d] = 1'b1; req_valid[d] = '0; req_data[d] = '0; req_last[d] = '0;
            log_n[d] = 0; left[d] = 0; pre[d] = 0;
            for (int i = 0; i < N; i++) rd_cnt[d][i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                acc[d]   = tx_en && tx_vld[d] && tx_rdy[d];
                acc_b[d] = {gid[d], tx_data[d]};
                cons[d]  = tx_en ? (req_valid[d] & req_ready[d]) : '0;
            end
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (acc[d]) begin
                    log_q[d][log_n[d] % 64] = acc_b[d];
                    log_n[d]++;
                    if (!stuck[d]) begin
                        if (dly[d] == 0) begin tx_rdy[d] = 1'b0; left[d] = 3; end
                        else pre[d] = dly[d];
                    end
                end else if (pre[d] > 0) begin
                    pre[d]--;
                    if (pre[d] == 0) begin tx_rdy[d] = 1'b0; left[d] = 3; end
                end else if (left[d] > 0) begin
                    left[d]--;
                    if (left[d] == 0) tx_rdy[d] = 1'b1;
                end
                for (int i = 0; i < N; i++) begin
                    if (cons[d][i]) rd_cnt[d][i]++;
                    req_valid[d][i] = (wr_cnt[d][i] != rd_cnt[d][i]);
                    {req_last[d][i], req_data[d][8*i +: 8]} = mem[d][i][rd_cnt[d][i] % 16];
                end
            end
        end
    end

    task automatic push(input int d, input int i, input logic [7:0] b, input logic l);
        mem[d][i][wr_cnt[d][i] % 16] = {l, b};
        wr_cnt[d][i]++;
    endtask

    task automatic do_reset();
        @(posedge clk); #2; tx_en = 1'b0;
        @(posedge clk); #2; tx_en = 1'b1;
    endtask

    task automatic wait_done(input int d, input int target, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (log_n[d] >= target && !busy[d] && !tx_vld[d]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        push(0, 3, 8'hC3, 1'b1);
        repeat (3) @(negedge clk);
        vectors++; if (req_ready[0] !== 4'b0000) begin fails++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready[0]); end
        vectors++; if (tx_vld[0] !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", tx_vld[0]); end
        vectors++; if (tx_data[0] !== 8'h00) begin fails++; $display("FAIL rst_data: got %h expected 00", tx_data[0]); end
        vectors++; if (gid[0] !== 2'd0) begin fails++; $display("FAIL rst_grant: got %0d expected 0", gid[0]); end
        vectors++; if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b%b expected 00", busy[0], busy[1]); end
        vectors++; if (err[0] !== 1'b0 || tx_vld[1] !== 1'b0) begin fails++; $display("FAIL rst_err_vld: got %b%b expected 00", err[0], tx_vld[1]); end
        wr_cnt[0][3] = rd_cnt[0][3];
        repeat (2) @(negedge clk);
        @(posedge clk); #2; tx_en = 1'b1;
        @(negedge clk);
        vectors++; if (busy[0] !== 1'b0 || req_ready[0] !== 4'b0000) begin fails++; $display("FAIL rst_idle: got busy %b ready %b expected 0 0000", busy[0], req_ready[0]); end
    endtask

    task automatic test_single_byte();
        int base;
        base = log_n[0];
        @(negedge clk); push(0, 2, 8'hA5, 1'b1);
        @(negedge clk);
        vectors++; if (req_ready[0] !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b expected 0100", req_ready[0]); end
        @(negedge clk);
        vectors++; if (tx_vld[0] !== 1'b1 || tx_data[0] !== 8'hA5) begin fails++; $display("FAIL single_offer: got %b/%h expected 1/a5", tx_vld[0], tx_data[0]); end
        vectors++; if (gid[0] !== 2'd2 || busy[0] !== 1'b1) begin fails++; $display("FAIL single_grant: got %0d/%b expected 2/1", gid[0], busy[0]); end
        vectors++; if (req_ready[0] !== 4'b0000) begin fails++; $display("FAIL single_ready_once: got %b expected 0000", req_ready[0]); end
        @(negedge clk);
        vectors++; if (tx_vld[0] !== 1'b0 || busy[0] !== 1'b1) begin fails++; $display("FAIL single_accept: got vld %b busy %b expected 0 1", tx_vld[0], busy[0]); end
        repeat (3) @(negedge clk);
        vectors++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL single_wait: got %b expected 1", busy[0]); end
        @(negedge clk);
        vectors++; if (busy[0] !== 1'b0 || gid[0] !== 2'd2) begin fails++; $display("FAIL single_release: got busy %b grant %0d expected 0 2", busy[0], gid[0]); end
        vectors++; if (log_n[0] !== base + 1 || log_q[0][base % 64] !== {2'd2, 8'hA5}) begin fails++; $display("FAIL single_log: got n=%0d %h expected n=%0d 2a5", log_n[0] - base, log_q[0][base % 64], 1); end
    endtask

    task automatic test_round_robin();
        int base; logic ok; logic [9:0] exp;
        do_reset();
        base = log_n[0];
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            push(0, 0, 8'(k), 1'b1);
            push(0, 1, 8'(8'h10 + k), 1'b1);
        end
        wait_done(0, base + 8, ok);
        vectors++; if (ok !== 1'b1) begin fails++; $display("FAIL rr_timeout: got %0d bytes expected 8", log_n[0] - base); end
        for (int k = 0; k < 8; k++) begin
            exp = (k % 2 == 0) ? {2'd0, 8'(k / 2)} : {2'd1, 8'(8'h10 + k / 2)};
            vectors++; if (log_q[0][(base + k) % 64] !== exp) begin fails++; $display("FAIL rr_order[%0d]: got %h expected %h", k, log_q[0][(base + k) % 64], exp); end
        end
    endtask

    task automatic test_packet_lock();
        int base; logic ok; logic [9:0] exp [5];
        exp[0] = {2'd2, 8'h5A}; exp[1] = {2'd3, 8'h11}; exp[2] = {2'd3, 8'h22};
        exp[3] = {2'd3, 8'h33}; exp[4] = {2'd0, 8'h77};
        do_reset();
        base = log_n[0];
        @(negedge clk); push(0, 2, 8'h5A, 1'b1);
        wait_done(0, base + 1, ok);
        @(negedge clk);
        push(0, 3, 8'h11, 1'b0); push(0, 3, 8'h22, 1'b0); push(0, 3, 8'h33, 1'b1);
        push(0, 0, 8'h77, 1'b1);
        wait_done(0, base + 5, ok);
        vectors++; if (ok !== 1'b1) begin fails++; $display("FAIL lock_timeout: got %0d bytes expected 5", log_n[0] - base); end
        for (int k = 0; k < 5; k++) begin
            vectors++; if (log_q[0][(base + k) % 64] !== exp[k]) begin fails++; $display("FAIL lock_order[%0d]: got %h expected %h", k, log_q[0][(base + k) % 64], exp[k]); end
        end
    endtask

    task automatic test_burst_cap();
        int base; logic ok; logic [9:0] exp [6];
        exp[0] = {2'd1, 8'h40}; exp[1] = {2'd1, 8'h41}; exp[2] = {2'd2, 8'h50};
        exp[3] = {2'd1, 8'h42}; exp[4] = {2'd1, 8'h43}; exp[5] = {2'd1, 8'h44};
        do_reset();
        base = log_n[1];
        @(negedge clk);
        for (int k = 0; k < 5; k++) push(1, 1, 8'(8'h40 + k), 1'b0);
        push(1, 2, 8'h50, 1'b1);
        wait_done(1, base + 6, ok);
        vectors++; if (ok !== 1'b1) begin fails++; $display("FAIL burst_timeout: got %0d bytes expected 6", log_n[1] - base); end
        for (int k = 0; k < 6; k++) begin
            vectors++; if (log_q[1][(base + k) % 64] !== exp[k]) begin fails++; $display("FAIL burst_order[%0d]: got %h expected %h", k, log_q[1][(base + k) % 64], exp[k]); end
        end
    endtask

    task automatic test_timeout();
        int base;
        do_reset();
        stuck[0] = 1'b1;
        base = log_n[0];
        @(negedge clk); push(0, 1, 8'h3C, 1'b1);
        @(negedge clk);
        vectors++; if (req_ready[0] !== 4'b0010) begin fails++; $display("FAIL tmo_ready: got %b expected 0010", req_ready[0]); end
        @(negedge clk);
        vectors++; if (tx_vld[0] !== 1'b1) begin fails++; $display("FAIL tmo_offer: got %b expected 1", tx_vld[0]); end
        for (int n = 3; n <= 10; n++) begin
            @(negedge clk);
            vectors++; if (err[0] !== 1'b0 || busy[0] !== 1'b1) begin fails++; $display("FAIL tmo_early[%0d]: got err %b busy %b expected 0 1", n, err[0], busy[0]); end
        end
        @(negedge clk);
        vectors++; if (err[0] !== 1'b1 || busy[0] !== 1'b0) begin fails++; $display("FAIL tmo_pulse: got err %b busy %b expected 1 0", err[0], busy[0]); end
        @(negedge clk);
        vectors++; if (err[0] !== 1'b0) begin fails++; $display("FAIL tmo_one_cycle: got %b expected 0", err[0]); end
        vectors++; if (log_q[0][base % 64] !== {2'd1, 8'h3C}) begin fails++; $display("FAIL tmo_log: got %h expected 13c", log_q[0][base % 64]); end
        stuck[0] = 1'b0;
    endtask

    task automatic test_fall_beats_timeout();
        logic err_seen;
        dly[0] = 7;
        err_seen = 1'b0;
        @(negedge clk); push(0, 2, 8'h66, 1'b1);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            err_seen = err_seen | err[0];
            if (n == 11) begin
                vectors++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL fall_still_busy: got %b expected 1", busy[0]); end
            end
            if (n == 14) begin
                vectors++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL fall_complete: got %b expected 0", busy[0]); end
            end
        end
        vectors++; if (err_seen !== 1'b0) begin fails++; $display("FAIL fall_no_err: got %b expected 0", err_seen); end
        dly[0] = 0;
    endtask

    task automatic test_reset_mid();
        int base; logic ok;
        base = log_n[0];
        @(negedge clk); push(0, 2, 8'h99, 1'b1);
        @(negedge clk);
        vectors++; if (req_ready[0] !== 4'b0100) begin fails++; $display("FAIL mid_ready: got %b expected 0100", req_ready[0]); end
        @(posedge clk); #2; tx_en = 1'b0;
        @(negedge clk);
        vectors++; if (tx_vld[0] !== 1'b1 || req_ready[0] !== 4'b0000) begin fails++; $display("FAIL mid_offer: got vld %b ready %b expected 1 0000", tx_vld[0], req_ready[0]); end
        @(posedge clk); #2; tx_en = 1'b1;
        @(negedge clk);
        vectors++; if (tx_vld[0] !== 1'b0 || tx_data[0] !== 8'h00 || gid[0] !== 2'd0 || busy[0] !== 1'b0 || err[0] !== 1'b0) begin
            fails++; $display("FAIL mid_outputs: got vld %b data %h grant %0d busy %b err %b expected all 0", tx_vld[0], tx_data[0], gid[0], busy[0], err[0]);
        end
        repeat (10) @(negedge clk);
        vectors++; if (log_n[0] !== base) begin fails++; $display("FAIL mid_dropped: got %0d bytes expected 0", log_n[0] - base); end
        push(0, 3, 8'h03, 1'b1); push(0, 0, 8'h01, 1'b1);
        wait_done(0, base + 2, ok);
        vectors++; if (ok !== 1'b1 || log_q[0][base % 64] !== {2'd0, 8'h01}) begin fails++; $display("FAIL mid_prio0: got %h ok %b expected 001 1", log_q[0][base % 64], ok); end
        vectors++; if (log_q[0][(base + 1) % 64] !== {2'd3, 8'h03}) begin fails++; $display("FAIL mid_next: got %h expected 303", log_q[0][(base + 1) % 64]); end
    endtask

    initial begin
        tx_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            stuck[d] = 1'b0; dly[d] = 0;
            for (int i = 0; i < N; i++) begin
                wr_cnt[d][i] = 0;
                for (int k = 0; k < 16; k++) mem[d][i][k] = 9'h000;
            end
        end
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_burst_cap();
        test_timeout();
        test_fall_beats_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
